// File: rtl/uart_rx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_pkg
//  Description : Shared types and constants for the UART receive engine:
//                FSM state encoding, line-control bit positions and the
//                received-character FIFO entry layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkg;

    // Receive FSM states, explicitly encoded in 3 bits
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP1  = 3'd4,
        ST_STOP2  = 3'd5
    } uart_rx_state_t;

    // Line-control register bit positions
    localparam int c_lcr_wls_lo = 0;  // word length select, 2 bits: 5..8
    localparam int c_lcr_wls_hi = 1;
    localparam int c_lcr_stb    = 2;  // two stop bits
    localparam int c_lcr_pen    = 3;  // parity enable
    localparam int c_lcr_eps    = 4;  // even parity select
    localparam int c_lcr_stick  = 5;  // stick parity

    // One received character with its status flags
    typedef struct packed {
        logic       brk;
        logic       fe;
        logic       pe;
        logic [7:0] data;
    } uart_rx_entry_t;

endpackage : uart_rx_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Small received-character FIFO. Head entry is presented
//                combinationally and zeroed when empty. A push into a full
//                FIFO is dropped (overrun pulse) unless a pop happens in the
//                same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_push,
    input  uart_rx_entry_t i_push_entry,
    input  logic           i_ready,
    output logic           o_valid,
    output uart_rx_entry_t o_head,
    output logic           o_overrun
);

    localparam int                 c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(DEPTH);

    uart_rx_entry_t       r_mem [DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_wr;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == c_depth);
    assign w_pop     = !w_empty && i_ready;
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts
    assign w_wr      = i_push && (!w_full || w_pop);
    assign o_overrun = i_push && w_full && !w_pop;
    assign o_valid   = !w_empty;
    assign o_head    = w_empty ? '0 : r_mem[r_rd_ptr];

    // Storage array; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_entry;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

endmodule : uart_rx_fifo
`default_nettype wire

// File: rtl/uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_engine
//  Description : Oversampling UART receiver with programmable baud divisor,
//                5..8 data bits, optional/stick parity, 1 or 2 stop bits,
//                break detection and a small character FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_engine
    import uart_rx_pkg::*;
#(
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic [15:0] divisor,
    input  logic [7:0]  lcr,
    input  logic        rxd,
    input  logic        rx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_pe,
    output logic        rx_fe,
    output logic        rx_brk,
    output logic        sbe,
    output logic        overrun
);

    localparam int                c_os_w    = $clog2(OVERSAMPLE);
    localparam logic [c_os_w-1:0] c_os_last = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_os_w-1:0] c_os_half = c_os_w'(OVERSAMPLE / 2 - 1);

    uart_rx_state_t    r_state;
    uart_rx_state_t    w_state_next;
    logic              r_rxd_meta;
    logic              r_rxd_sync;
    logic [15:0]       r_div;
    logic [15:0]       r_tick_cnt;
    logic              w_tick;
    logic [c_os_w-1:0] r_os_cnt;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_data;
    logic [5:0]        r_lcr;
    logic              r_pe;
    logic              r_fe;
    logic              r_all_zero;
    logic              r_armed;
    logic              w_sample;
    logic [2:0]        w_last_bit;
    logic              w_par_exp;
    logic              w_fe_final;
    logic              w_zero_final;
    logic              w_push;
    logic              w_sbe;
    logic              w_start_ok;
    uart_rx_entry_t    w_push_entry;
    uart_rx_entry_t    w_head;
    logic              w_lcr_unused;

    assign w_lcr_unused = &{1'b0, lcr[7:6]};

    // Two-flop synchroniser for the asynchronous serial input (idles high)
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    // Oversample tick divider; divisor is re-sampled only at each wrap
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_div      <= '0;
            r_tick_cnt <= '0;
        end else if (r_div == 16'd0 || w_tick) begin
            r_div      <= divisor;
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
        end
    end

    assign w_tick       = (r_div != 16'd0) && (r_tick_cnt == r_div - 16'd1);
    assign w_sample     = w_tick && (r_os_cnt == c_os_last);
    assign w_last_bit   = {1'b1, r_lcr[c_lcr_wls_hi:c_lcr_wls_lo]};
    assign w_par_exp    = r_lcr[c_lcr_stick] ? ~r_lcr[c_lcr_eps]
                                             : (^r_data) ^ ~r_lcr[c_lcr_eps];
    // Final stop sample folds the current line level into the frame status
    assign w_fe_final   = r_fe | ~r_rxd_sync;
    assign w_zero_final = r_all_zero & ~r_rxd_sync;
    assign w_start_ok   = !r_rxd_sync && r_armed;
    assign w_push_entry = {w_zero_final, w_fe_final, r_pe, r_data};

    // FSM state register
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state and push/false-start decode; every move is tick-qualified
    always_comb begin
        w_state_next = r_state;
        w_sbe        = 1'b0;
        w_push       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_tick && w_start_ok) begin
                    w_state_next = ST_START;
                end
            end
            ST_START: begin
                if (w_tick && r_rxd_sync) begin
                    w_sbe        = 1'b1;
                    w_state_next = ST_IDLE;
                end else if (w_tick && r_os_cnt == c_os_half) begin
                    w_state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_sample && r_bit_cnt == w_last_bit) begin
                    w_state_next = r_lcr[c_lcr_pen] ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (w_sample) begin
                    w_state_next = ST_STOP1;
                end
            end
            ST_STOP1: begin
                if (w_sample) begin
                    if (r_lcr[c_lcr_stb]) begin
                        w_state_next = ST_STOP2;
                    end else begin
                        w_push       = 1'b1;
                        w_state_next = ST_IDLE;
                    end
                end
            end
            ST_STOP2: begin
                if (w_sample) begin
                    w_push       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Frame datapath: bit timing, data assembly, status flags and re-arm
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            r_lcr      <= '0;
            r_os_cnt   <= '0;
            r_bit_cnt  <= '0;
            r_data     <= '0;
            r_pe       <= 1'b0;
            r_fe       <= 1'b0;
            r_all_zero <= 1'b0;
            r_armed    <= 1'b1;
        end else if (w_tick) begin
            if (r_rxd_sync) begin
                r_armed <= 1'b1;
            end
            // A framing error holds off re-triggering until the line goes idle
            if (w_push && w_fe_final) begin
                r_armed <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_start_ok) begin
                        r_lcr      <= lcr[5:0];
                        r_os_cnt   <= '0;
                        r_bit_cnt  <= '0;
                        r_data     <= '0;
                        r_pe       <= 1'b0;
                        r_fe       <= 1'b0;
                        r_all_zero <= 1'b1;
                    end
                end
                ST_START: begin
                    r_os_cnt <= (r_os_cnt == c_os_half) ? '0 : r_os_cnt + 1'b1;
                end
                default: begin
                    r_os_cnt <= (r_os_cnt == c_os_last) ? '0 : r_os_cnt + 1'b1;
                    if (r_os_cnt == c_os_last) begin
                        if (r_rxd_sync) begin
                            r_all_zero <= 1'b0;
                        end
                        case (r_state)
                            ST_DATA: begin
                                r_data[r_bit_cnt] <= r_rxd_sync;
                                r_bit_cnt         <= r_bit_cnt + 3'd1;
                            end
                            ST_PARITY: r_pe <= r_rxd_sync ^ w_par_exp;
                            ST_STOP1:  r_fe <= ~r_rxd_sync;
                            default:   ;
                        endcase
                    end
                end
            endcase
        end
    end

    uart_rx_fifo #(
        .DEPTH        (FIFO_DEPTH)
    ) u_fifo (
        .clk          (sclk),
        .rst_n        (rst_n),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_ready      (rx_ready),
        .o_valid      (rx_valid),
        .o_head       (w_head),
        .o_overrun    (overrun)
    );

    assign rx_data = w_head.data;
    assign rx_pe   = w_head.pe;
    assign rx_fe   = w_head.fe;
    assign rx_brk  = w_head.brk;
    assign sbe     = w_sbe;

endmodule : uart_rx_engine
`default_nettype wire

// File: tb/tb_uart_rx_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_engine
//  Description : Directed self-checking bench for uart_rx_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_engine;

    logic        sclk     = 1'b0;
    logic        rst_n    = 1'b0;
    logic [15:0] divisor  = 16'd4;
    logic [7:0]  lcr      = 8'h03;
    logic        rxd      = 1'b1;
    logic        rx_ready = 1'b0;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pe;
    logic        rx_fe;
    logic        rx_brk;
    logic        sbe;
    logic        overrun;

    int checks     = 0;
    int errors     = 0;
    int bit_cycles = 64;
    int sbe_cnt    = 0;
    int ovr_cnt    = 0;

    uart_rx_engine #(
        .OVERSAMPLE (16),
        .FIFO_DEPTH (4)
    ) dut (
        .sclk     (sclk),
        .rst_n    (rst_n),
        .divisor  (divisor),
        .lcr      (lcr),
        .rxd      (rxd),
        .rx_ready (rx_ready),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_pe    (rx_pe),
        .rx_fe    (rx_fe),
        .rx_brk   (rx_brk),
        .sbe      (sbe),
        .overrun  (overrun)
    );

    always #5 sclk = ~sclk;

    // Pulse counters for the one-cycle status outputs
    always @(negedge sclk) begin
        if (sbe)     sbe_cnt = sbe_cnt + 1;
        if (overrun) ovr_cnt = ovr_cnt + 1;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog");
    end

    // Drive n bits LSB first, each lasting bit_cycles clocks
    task automatic send_raw(input logic [15:0] bits, input int n);
        @(posedge sclk); #1;
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (bit_cycles) @(posedge sclk);
            #1;
        end
    endtask

    task automatic send_char(input logic [7:0] d, input int nbits, input bit par_en,
                             input bit par_bit, input int nstop);
        logic [15:0] b;
        int          n;
        b    = '1;
        b[0] = 1'b0;
        for (int i = 0; i < nbits; i++) b[1+i] = d[i];
        n = 1 + nbits;
        if (par_en) begin
            b[n] = par_bit;
            n    = n + 1;
        end
        send_raw(b, n + nstop);
    endtask

    // Capture the head entry, then pop it with a one-cycle ready
    task automatic pop_entry(output logic v, output logic [7:0] d, output logic pe,
                             output logic fe, output logic brk);
        @(negedge sclk);
        v = rx_valid; d = rx_data; pe = rx_pe; fe = rx_fe; brk = rx_brk;
        rx_ready = 1'b1;
        @(negedge sclk);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge sclk);
        rxd = 1'b0;
        repeat (3) @(negedge sclk);
        checks++;
        if ({rx_valid, rx_data, rx_pe, rx_fe, rx_brk, sbe, overrun} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required 0",
                     {rx_valid, rx_data, rx_pe, rx_fe, rx_brk, sbe, overrun});
        end
        rxd   = 1'b1;
        rst_n = 1'b1;
        repeat (30) @(negedge sclk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_valid: got %b required 0", rx_valid);
        end
    endtask

    task automatic test_8n1();
        logic v, pe, fe, brk;
        logic [7:0] d;
        divisor = 16'd4; lcr = 8'h03; bit_cycles = 64;
        send_char(8'hA5, 8, 1'b0, 1'b0, 1);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'hA5, 3'b000}) begin
            errors++;
            $display("FAIL 8n1_entry: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'hA5, 3'b000});
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL 8n1_single: got valid %b required 0", rx_valid);
        end
    endtask

    task automatic test_parity();
        logic v, pe, fe, brk;
        logic [7:0] d;
        // 7 bits even parity; 0x35 has four ones so the correct bit is 0
        lcr = 8'h1A;
        send_char(8'h35, 7, 1'b1, 1'b1, 1);
        lcr = 8'h03;  // changed mid-stream; the next frame latches it afresh
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h35, 3'b100}) begin
            errors++;
            $display("FAIL parity_even_bad: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h35, 3'b100});
        end
        lcr = 8'h1A;
        send_char(8'h35, 7, 1'b1, 1'b0, 1);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h35, 3'b000}) begin
            errors++;
            $display("FAIL parity_even_good: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h35, 3'b000});
        end
        // Odd parity, 6 bits, two stop bits: 0x2C has three ones so the odd bit is 0
        lcr = 8'h0D;
        send_char(8'h2C, 6, 1'b1, 1'b0, 2);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h2C, 3'b000}) begin
            errors++;
            $display("FAIL parity_odd_good: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h2C, 3'b000});
        end
        // Stick parity with eps=0 expects 1; sending 0 flags an error
        lcr = 8'h2B;
        send_char(8'h0F, 8, 1'b1, 1'b0, 1);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h0F, 3'b100}) begin
            errors++;
            $display("FAIL parity_stick: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h0F, 3'b100});
        end
        lcr = 8'h03;
    endtask

    task automatic test_false_start();
        int s0;
        s0 = sbe_cnt;
        @(posedge sclk); #1;
        rxd = 1'b0;
        repeat (12) @(posedge sclk);
        #1 rxd = 1'b1;
        repeat (700) @(negedge sclk);
        checks++;
        if (sbe_cnt - s0 !== 1) begin
            errors++;
            $display("FAIL false_start_sbe: got %0d pulses required 1", sbe_cnt - s0);
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL false_start_push: got valid %b required 0", rx_valid);
        end
    endtask

    task automatic test_break();
        logic v, pe, fe, brk;
        logic [7:0] d;
        lcr = 8'h03;
        @(posedge sclk); #1;
        rxd = 1'b0;
        repeat (1280) @(posedge sclk);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h00, 3'b011}) begin
            errors++;
            $display("FAIL break_entry: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h00, 3'b011});
        end
        repeat (300) @(negedge sclk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL break_retrigger: got valid %b required 0", rx_valid);
        end
        rxd = 1'b1;
        repeat (700) @(negedge sclk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL break_release: got valid %b required 0", rx_valid);
        end
    endtask

    task automatic test_overrun();
        logic v, pe, fe, brk;
        logic [7:0] d;
        logic [7:0] chars [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        int o0;
        o0 = ovr_cnt;
        for (int k = 0; k < 5; k++) send_char(chars[k], 8, 1'b0, 1'b0, 1);
        repeat (10) @(negedge sclk);
        checks++;
        if (ovr_cnt - o0 !== 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d required 1", ovr_cnt - o0);
        end
        for (int k = 0; k < 4; k++) begin
            pop_entry(v, d, pe, fe, brk);
            checks++;
            if ({v, d, pe, fe, brk} !== {1'b1, chars[k], 3'b000}) begin
                errors++;
                $display("FAIL overrun_order_%0d: got %h required %h", k, {v, d, pe, fe, brk}, {1'b1, chars[k], 3'b000});
            end
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL overrun_drop: got valid %b required 0", rx_valid);
        end
    endtask

    task automatic test_full_push_pop();
        logic v, pe, fe, brk;
        logic [7:0] d;
        logic [7:0] exp_q [4] = '{8'hC3, 8'h3C, 8'h96, 8'h69};
        int lat;
        int o0;
        bit found;
        divisor = 16'd1; bit_cycles = 16;
        repeat (20) @(posedge sclk);
        o0 = ovr_cnt; lat = 0; found = 1'b0;
        // Measure start-edge to rx_valid latency; with one tick per clock it is fixed
        fork
            send_char(8'h5A, 8, 1'b0, 1'b0, 1);
            begin
                @(posedge sclk); #1;
                for (int i = 0; i < 400 && !found; i++) begin
                    @(negedge sclk);
                    lat++;
                    if (rx_valid) found = 1'b1;
                end
            end
        join
        checks++;
        if (found !== 1'b1) begin
            errors++;
            $display("FAIL full_calibrate: got no rx_valid within %0d cycles required valid", lat);
            lat = 2;
        end
        for (int k = 0; k < 3; k++) send_char(exp_q[k], 8, 1'b0, 1'b0, 1);
        // Fifth frame: ready high exactly in the cycle its push lands
        fork
            send_char(exp_q[3], 8, 1'b0, 1'b0, 1);
            begin
                @(posedge sclk); #1;
                repeat (lat - 1) @(negedge sclk);
                rx_ready = 1'b1;
                @(negedge sclk);
                rx_ready = 1'b0;
            end
        join
        repeat (5) @(negedge sclk);
        checks++;
        if (ovr_cnt - o0 !== 0) begin
            errors++;
            $display("FAIL full_push_pop_overrun: got %0d pulses required 0", ovr_cnt - o0);
        end
        for (int k = 0; k < 4; k++) begin
            pop_entry(v, d, pe, fe, brk);
            checks++;
            if ({v, d, pe, fe, brk} !== {1'b1, exp_q[k], 3'b000}) begin
                errors++;
                $display("FAIL full_order_%0d: got %h required %h", k, {v, d, pe, fe, brk}, {1'b1, exp_q[k], 3'b000});
            end
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_drain: got valid %b required 0", rx_valid);
        end
        divisor = 16'd4; bit_cycles = 64;
        repeat (20) @(posedge sclk);
    endtask

    task automatic test_divisor_zero();
        logic v, pe, fe, brk;
        logic [7:0] d;
        divisor = 16'd0;
        repeat (20) @(posedge sclk);
        send_char(8'h81, 8, 1'b0, 1'b0, 1);
        repeat (10) @(negedge sclk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL div0_halt: got valid %b required 0", rx_valid);
        end
        divisor = 16'd4;
        repeat (20) @(posedge sclk);
        send_char(8'h81, 8, 1'b0, 1'b0, 1);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h81, 3'b000}) begin
            errors++;
            $display("FAIL div0_resume: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h81, 3'b000});
        end
    endtask

    task automatic test_reset_midframe();
        logic v, pe, fe, brk;
        logic [7:0] d;
        @(posedge sclk); #1;
        rxd = 1'b0;
        repeat (3 * 64) @(posedge sclk);
        @(negedge sclk);
        rst_n = 1'b0;
        rxd   = 1'b1;
        repeat (5) @(negedge sclk);
        rst_n = 1'b1;
        repeat (700) @(negedge sclk);
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_discard: got valid %b required 0", rx_valid);
        end
        send_char(8'h3C, 8, 1'b0, 1'b0, 1);
        pop_entry(v, d, pe, fe, brk);
        checks++;
        if ({v, d, pe, fe, brk} !== {1'b1, 8'h3C, 3'b000}) begin
            errors++;
            $display("FAIL midreset_restart: got %h required %h", {v, d, pe, fe, brk}, {1'b1, 8'h3C, 3'b000});
        end
        checks++;
        if (rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_single: got valid %b required 0", rx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_break();
        test_overrun();
        test_full_push_pop();
        test_divisor_zero();
        test_reset_midframe();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_uart_rx_engine
`default_nettype wire

// File: doc/uart_rx_engine.md
UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 Parameter OVERSAMPLE, default 16, ticks per bit (even, >=8).
REQ-002 Parameter FIFO_DEPTH, default 4, received-character FIFO entries (power of 2, >=2).
REQ-003 sclk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 divisor  in  16  sclk cycles per oversample tick; 0 halts tick generation.
REQ-006 lcr  in  8  [1:0] word length 5..8, [2] two stop bits, [3] parity enable, [4] even parity, [5] stick parity.
REQ-007 rxd  in  1  asynchronous serial input, idle high.
REQ-008 rx_ready  in  1  consumer accepts head entry.
REQ-009 rx_valid  out  1  FIFO non-empty.
REQ-010 rx_data  out  8  head character, unused MSBs zero; 0 when rx_valid=0.
REQ-011 rx_pe / rx_fe / rx_brk  out  1 each  parity, framing, break flags of head entry; 0 when rx_valid=0.
REQ-012 sbe  out  1  one-cycle pulse on false start bit.
REQ-013 overrun  out  1  one-cycle pulse when a completed character is dropped.

Function
REQ-014 rxd SHALL pass a 2-flop synchroniser; all logic uses the synchronised value.
REQ-015 Tick counter SHALL count 0..divisor-1, asserting tick for one sclk when it reaches divisor-1; a new divisor takes effect at the next wrap.
REQ-016 FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2; all transitions occur on tick only.
REQ-017 IDLE->START when rxd=0 on a tick and the armed flag is set; lcr SHALL be latched on this transition, and later lcr changes SHALL NOT affect the frame.
REQ-018 START: if rxd=1 on any of the next OVERSAMPLE/2 ticks, pulse sbe and return to IDLE; otherwise go to DATA at the start-bit midpoint.
REQ-019 DATA: sample one bit every OVERSAMPLE ticks, LSB first, 5+lcr[1:0] bits; then go to PARITY if lcr[3], else STOP1.
REQ-020 Expected parity: stick (lcr[5]=1) -> ~lcr[4]; else XOR of data bits, inverted when lcr[4]=0 (odd). pe = sampled parity != expected.
REQ-021 STOP1 sample: fe=1 if 0. If lcr[2]=1, go to STOP2, which samples again and ORs its result into fe.
REQ-022 brk=1 when all data bits, the parity bit (if present) and every stop sample are 0.
REQ-023 Push {brk,fe,pe,data} into the FIFO on the final stop-sample tick, then enter IDLE immediately (mid-stop resync); rx_valid is high on the following sclk.
REQ-024 After a frame with fe=1, the armed flag SHALL clear; it sets again only once rxd=1 is sampled on a tick, so a break does not retrigger.
REQ-025 Pop occurs when rx_valid && rx_ready, and the next head entry appears on the following cycle.
REQ-026 Push when full and no pop: drop the new entry, pulse overrun, leave contents unchanged.
REQ-027 Push and pop in the same cycle when full: both take effect, and overrun stays 0.
REQ-028 Push and pop in the same cycle when the count is 1: rx_valid stays 1 and the new entry becomes head.
REQ-029 divisor=0 mid-frame: the FSM freezes in its current state until ticks resume.

Reset
REQ-030 rst_n low: FSM=IDLE, armed=1, counters=0, FIFO empty, synchroniser flops=1.
REQ-031 Outputs rx_valid, rx_data, rx_pe, rx_fe, rx_brk, sbe and overrun SHALL all be 0 while in reset.
REQ-032 Reset mid-frame: the partial character is discarded, and reception restarts on the next valid start bit after release.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the FSM state enum, the lcr bit-index constants and the FIFO entry struct {brk,fe,pe,data[7:0]}.
REQ-034 FIFO SHALL be the sub-module uart_rx_fifo (parameter DEPTH, entry type from the package).
REQ-035 Target size is 120-400 lines of RTL including the FIFO.

Verification
REQ-036 divisor=4, lcr=0x03, send 0xA5 8N1 -> one entry 0xA5, pe=fe=brk=0.
REQ-037 lcr=0x1A (7 bits, even parity), send 0x35 with parity bit 1 -> data 0x35, pe=1.
REQ-038 rxd low for 3 ticks then high -> sbe pulses once, no FIFO push.
REQ-039 rxd held low for 2 frame times, lcr=0x03 -> one entry data 0x00, fe=1, brk=1; no second entry until rxd returns high.
REQ-040 FIFO_DEPTH=4, rx_ready=0, send 5 characters -> 4 retained in order, overrun pulses once on the 5th.
REQ-041 FIFO full, rx_ready=1 in the same cycle as the 5th push -> overrun=0, and the 5th character is read last.
